// File: rtl/obi_dual_port_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between the instruction
// (M0) and data (M1) interfaces, with in-order response routing via an ID FIFO.
module obi_dual_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // instruction requester
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  // data requester
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  // shared memory port
  output logic                  s_req_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_wdata_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  input  logic [31:0]           s_rdata_i,
  // status
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic SEL_M0 = 1'b0;
  localparam logic SEL_M1 = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic                       lock_sel_q;
  logic                       rr_last_q;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       err_q;

  logic sel_c;
  logic req_sel_c;
  logic full_c;
  logic gnt_in_c;
  logic xfer_c;
  logic lock_c;
  logic pop_c;
  logic head_c;

  // Pointer advance with wrap at the FIFO depth (depth need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c        = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: lock on an ungranted request, release on grant
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (lock_c)   state_d = ST_LOCKED;
      ST_LOCKED: if (gnt_in_c) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: selection, memory-side mux, grant pass-through, response routing
  always_comb begin
    sel_c       = SEL_M0;
    req_sel_c   = 1'b0;
    s_req_o     = 1'b0;
    s_addr_o    = '0;
    s_we_o      = 1'b0;
    s_be_o      = 4'h0;
    s_wdata_o   = 32'h0;
    gnt_in_c    = 1'b0;
    xfer_c      = 1'b0;
    lock_c      = 1'b0;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    pop_c       = 1'b0;
    head_c      = SEL_M0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = 32'h0;
    m1_rdata_o  = 32'h0;

    if (state_q == ST_LOCKED) begin
      sel_c = lock_sel_q;
    end else if (m0_req_i && m1_req_i) begin
      sel_c = ~rr_last_q;
    end else if (m1_req_i) begin
      sel_c = SEL_M1;
    end

    req_sel_c = (sel_c == SEL_M1) ? m1_req_i : m0_req_i;
    // A held lock keeps its request visible even if the window fills
    s_req_o   = req_sel_c & (~full_c | (state_q == ST_LOCKED));

    if (s_req_o) begin
      if (sel_c == SEL_M1) begin
        s_addr_o  = m1_addr_i;
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_addr_o  = m0_addr_i;
        s_be_o    = 4'hF;
      end
    end

    gnt_in_c = s_gnt_i & ~full_c;
    xfer_c   = gnt_in_c & s_req_o;
    lock_c   = (state_q == ST_IDLE) & s_req_o & ~s_gnt_i;
    m0_gnt_o = xfer_c & (sel_c == SEL_M0);
    m1_gnt_o = xfer_c & (sel_c == SEL_M1);

    pop_c  = s_rvalid_i & (cnt_q != '0);
    head_c = id_fifo_q[rd_ptr_q];
    m0_rvalid_o = pop_c & (head_c == SEL_M0);
    m1_rvalid_o = pop_c & (head_c == SEL_M1);
    m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'h0;
    m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'h0;
  end

  // Lock selection, round-robin history, ID FIFO, outstanding count, sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_sel_q <= SEL_M0;
      rr_last_q  <= SEL_M1;
      id_fifo_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (lock_c) begin
        lock_sel_q <= sel_c;
      end
      if (xfer_c) begin
        id_fifo_q[wr_ptr_q] <= sel_c;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
        rr_last_q           <= sel_c;
      end
      if (pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (xfer_c && !pop_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (!xfer_c && pop_c) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (s_rvalid_i && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
